// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/forward control for the 5-stage core, driven from a shadow EX/MEM/WB scoreboard.
// Define HAZARD_PERF_CNT_EN to add the saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
   parameter int RF_ADDRESS = 5,
   parameter int LD_LAT     = 1,
   parameter int MC_TIMEOUT = 64,
   parameter int CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  id_valid,
   input  logic [RF_ADDRESS-1:0] id_rs1,
   input  logic [RF_ADDRESS-1:0] id_rs2,
   input  logic                  id_rs1_used,
   input  logic                  id_rs2_used,
   input  logic [RF_ADDRESS-1:0] id_rd,
   input  logic                  id_reg_write,
   input  logic                  id_mem_read,
   input  logic                  id_multicycle,
   input  logic                  br_taken,
   input  logic                  mc_done,
   output logic                  pc_stall,
   output logic                  if_id_stall,
   output logic                  if_id_flush,
   output logic                  id_ex_bubble,
   output logic                  id_ex_hold,
   output logic                  ex_mem_bubble,
   output logic [1:0]            fwd_a_sel,
   output logic [1:0]            fwd_b_sel,
   output logic                  mc_start,
   output logic                  mc_busy,
   output logic                  mc_timeout_err
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]      perf_stall_cnt,
   output logic [CNT_W-1:0]      perf_flush_cnt
`endif
);
   localparam int TW = $clog2(MC_TIMEOUT + 1);
   typedef logic [RF_ADDRESS-1:0] reg_t;
   typedef struct packed {
      logic valid;
      reg_t rd;
      logic reg_write;
      logic mem_read;
      logic multicycle;
      reg_t rs1;
      reg_t rs2;
      logic rs1_used;
      logic rs2_used;
   } ex_t;
   typedef struct packed {
      logic valid;
      reg_t rd;
      logic reg_write;
      logic mem_read;
   } mem_t;
   typedef struct packed {
      logic valid;
      reg_t rd;
      logic reg_write;
   } wb_t;
   typedef enum logic {RUN, BUSY} state_t;

   ex_t           ex_q, ex_d;
   mem_t          mem_q, mem_d;
   wb_t           wb_q, wb_d;
   state_t        state_q, state_d;
   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic          err_q, err_d;
   logic          ex_mc, tmo, frz, brk, lu, lu_ex, lu_mem;

   function automatic logic hit(input reg_t src, input logic used, input logic valid,
                                input logic reg_write, input reg_t rd);
      return used && src != '0 && valid && reg_write && src == rd;
   endfunction

   function automatic logic [1:0] fwd(input reg_t src, input logic used, input mem_t m, input wb_t w);
      return (hit(src, used, m.valid, m.reg_write, m.rd) && !m.mem_read) ? 2'b10 :
             hit(src, used, w.valid, w.reg_write, w.rd) ? 2'b01 : 2'b00;
   endfunction

   always_comb begin
      ex_mc = ex_q.valid && ex_q.multicycle;
      tmo = state_q == BUSY && tmo_cnt_q == TW'(MC_TIMEOUT - 1);
      frz = ex_mc && !(state_q == BUSY && (mc_done || tmo));
      brk = br_taken && !ex_mc;
      lu_ex = ex_q.mem_read &&
              (hit(id_rs1, id_rs1_used, ex_q.valid, ex_q.reg_write, ex_q.rd) ||
               hit(id_rs2, id_rs2_used, ex_q.valid, ex_q.reg_write, ex_q.rd));
      lu_mem = LD_LAT == 2 && mem_q.mem_read &&
               (hit(id_rs1, id_rs1_used, mem_q.valid, mem_q.reg_write, mem_q.rd) ||
                hit(id_rs2, id_rs2_used, mem_q.valid, mem_q.reg_write, mem_q.rd));
      lu = id_valid && (lu_ex || lu_mem);
      // A taken branch squashes the load consumer, so it must not also stall the PC.
      pc_stall = frz || (lu && !brk);
      if_id_stall = pc_stall;
      if_id_flush = brk;
      id_ex_bubble = !frz && (brk || lu);
      id_ex_hold = frz;
      ex_mem_bubble = frz;
      fwd_a_sel = fwd(ex_q.rs1, ex_q.rs1_used, mem_q, wb_q);
      fwd_b_sel = fwd(ex_q.rs2, ex_q.rs2_used, mem_q, wb_q);
      mc_busy = state_q == BUSY;
      mc_timeout_err = err_q;
   end

   always_comb begin
      ex_d = id_ex_bubble ? '0 : id_ex_hold ? ex_q :
             ex_t'{valid: id_valid, rd: id_rd, reg_write: id_reg_write, mem_read: id_mem_read,
                   multicycle: id_multicycle, rs1: id_rs1, rs2: id_rs2,
                   rs1_used: id_rs1_used, rs2_used: id_rs2_used};
      mem_d = ex_mem_bubble ? '0 :
              mem_t'{valid: ex_q.valid, rd: ex_q.rd, reg_write: ex_q.reg_write, mem_read: ex_q.mem_read};
      wb_d = wb_t'{valid: mem_q.valid, rd: mem_q.rd, reg_write: mem_q.reg_write};
   end

   always_comb begin
      state_d = state_q;
      tmo_cnt_d = tmo_cnt_q;
      err_d = err_q;
      mc_start = 1'b0;
      if (state_q == RUN) begin
         if (ex_mc) begin
            state_d = BUSY;
            tmo_cnt_d = '0;
            mc_start = 1'b1;
         end
      end else if (mc_done || tmo) begin
         state_d = RUN;
         err_d = err_q || !mc_done;
      end else begin
         tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ex_q <= '0;
         mem_q <= '0;
         wb_q <= '0;
         state_q <= RUN;
         tmo_cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         ex_q <= ex_d;
         mem_q <= mem_d;
         wb_q <= wb_d;
         state_q <= state_d;
         tmo_cnt_q <= tmo_cnt_d;
         err_q <= err_d;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q + CNT_W'(pc_stall && !(&stall_cnt_q));
      flush_cnt_d = flush_cnt_q + CNT_W'(if_id_flush && !(&flush_cnt_q));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign perf_stall_cnt = stall_cnt_q;
   assign perf_flush_cnt = flush_cnt_q;
`endif
endmodule
